// File: rtl/keypad_pkg.sv
// keypad_pkg -- shared constants for the keypad scanner / FIFO peripheral.
//   READY_BIT, OVF_BIT, COUNT_LSB : status register layout on keyout
//   HEX_LEGEND                    : raw 4x4 code -> legacy hex legend
//   clog2                         : constant ceil(log2) helper
package keypad_pkg;

  localparam int READY_BIT = 0;
  localparam int OVF_BIT   = 1;
  localparam int COUNT_LSB = 8;

  // Index = row*4 + col.  Rows: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  localparam logic [3:0] HEX_LEGEND [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/keypad_key_fifo.sv
// keypad_key_fifo -- synchronous key-code FIFO.
//   clk, rst  : clock, synchronous active-high reset
//   i_push    : write i_data (accepted when not full, or when full with a pop)
//   i_pop     : drop head entry (ignored when empty)
//   i_data    : code to write
//   o_full, o_empty, o_count : occupancy (count is AW+1 bits)
//   o_head    : head entry, forced to 0 when empty
module keypad_key_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 4,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  output logic [W-1:0]  o_head
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;

  logic w_do_push;
  logic w_do_pop;

  assign o_full   = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty  = (r_cnt == '0);
  assign o_count  = r_cnt;
  assign o_head   = o_empty ? '0 : r_mem[r_rd];

  // When full, a concurrent pop frees the slot the push lands in
  // (wr == rd), so both may proceed.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo -- ROWS x COLS keypad scanner with per-row debounce,
// key encoding and a key-code FIFO, exposed as a status/data bus register.
//   clk, rst      : clock, synchronous active-high reset
//   rowwrite      : row drive, one-hot active-low, advances every scan tick
//   colread       : column sense, active-low
//   ack           : CPU strobe; rising edge pops (data view) or clears
//                   overflow (status view)
//   statusordata  : 1 = status on keyout, 0 = FIFO head on keyout
//   keyout        : status {count[15:8], ovf[1], ready[0]} or head code
// Build option: define KEYPAD_HEXMAP_EN (4x4 only) to store the legacy hex
// legend instead of row*COLS+col.
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 14,
  parameter int DEBOUNCE   = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic [ROWS-1:0] rowwrite,
  input  logic [COLS-1:0] colread,
  input  logic            ack,
  input  logic            statusordata,
  output logic [15:0]     keyout
);

  localparam int ROW_W  = clog2(ROWS);
  localparam int COL_W  = clog2(COLS);
  localparam int CODE_W = clog2(ROWS*COLS);
  localparam int CNT_W  = clog2(FIFO_DEPTH) + 1;

  logic [SCAN_DIV-1:0]             r_div;
  logic [ROWS-1:0]                 r_rowwrite;
  // Only DEBOUNCE-1 past samples are kept; the current sample completes
  // the window.
  logic [ROWS-1:0][DEBOUNCE-2:0]   r_sh;
  logic [ROWS-1:0]                 r_db;
  logic [ROWS-1:0][COL_W-1:0]      r_col;
  logic                            r_any_q;
  logic                            r_ack_q;
  logic                            r_ovf;

  logic                            w_tick;
  logic                            w_pressed;
  logic [COL_W-1:0]                w_col;
  logic [ROWS-1:0][DEBOUNCE-1:0]   w_win;
  logic [ROW_W-1:0]                w_row;
  logic [CODE_W-1:0]               w_raw;
  logic [CODE_W-1:0]               w_push_code;
  logic                            w_event;
  logic                            w_ack_rise;
  logic                            w_pop;
  logic                            w_ovf_set;
  logic                            w_ovf_clr;
  logic                            w_full;
  logic                            w_empty;
  logic [CNT_W-1:0]                w_count;
  logic [CODE_W-1:0]               w_head;
  logic [15:0]                     w_status;

  assign rowwrite  = r_rowwrite;
  assign w_tick    = &r_div;
  assign w_pressed = ~&colread;

  // Lowest-numbered active-low column wins.
  always_comb begin
    w_col = '0;
    for (int c = COLS-1; c >= 0; c--)
      if (!colread[c]) w_col = COL_W'(c);
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++)
      w_win[r] = {r_sh[r], w_pressed};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div      <= '0;
      r_rowwrite <= {{(ROWS-1){1'b1}}, 1'b0};
      r_sh       <= '0;
      r_db       <= '0;
      r_col      <= '0;
      r_any_q    <= 1'b0;
      r_ack_q    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_div   <= r_div + SCAN_DIV'(1);
      r_any_q <= |r_db;
      r_ack_q <= ack;
      if (w_tick) begin
        r_rowwrite <= {r_rowwrite[ROWS-2:0], r_rowwrite[ROWS-1]};
        for (int r = 0; r < ROWS; r++) begin
          if (!r_rowwrite[r]) begin
            r_sh[r]  <= w_win[r][DEBOUNCE-2:0];
            r_col[r] <= w_col;
            if (&w_win[r])       r_db[r] <= 1'b1;
            else if (~|w_win[r]) r_db[r] <= 1'b0;
          end
        end
      end
      // A drop in the same cycle as a clear is newer, so it wins.
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  // Edge on |debounced gives one event per press: further rows going down
  // while one is held do not re-arm until everything is released.
  assign w_event = (|r_db) & ~r_any_q;

  always_comb begin
    w_row = '0;
    for (int r = ROWS-1; r >= 0; r--)
      if (r_db[r]) w_row = ROW_W'(r);
  end

  assign w_raw = CODE_W'(int'(w_row) * COLS + int'(r_col[w_row]));

`ifdef KEYPAD_HEXMAP_EN
  assign w_push_code = CODE_W'(HEX_LEGEND[w_raw]);
`else
  assign w_push_code = w_raw;
`endif

  assign w_ack_rise = ack & ~r_ack_q;
  assign w_pop      = w_ack_rise & ~statusordata;
  assign w_ovf_clr  = w_ack_rise & statusordata;
  assign w_ovf_set  = w_event & w_full & ~w_pop;

  keypad_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CODE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_event),
    .i_pop   (w_pop),
    .i_data  (w_push_code),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_comb begin
    w_status                        = '0;
    w_status[READY_BIT]             = ~w_empty;
    w_status[OVF_BIT]               = r_ovf;
    w_status[COUNT_LSB +: CNT_W]    = w_count;
  end

  assign keyout = statusordata ? w_status : 16'(w_head);

endmodule

// File: tb/tb_keypad_scan_fifo.sv
module tb_keypad_scan_fifo;

  localparam logic [63:0] LEGEND = 64'hDF0EC987B654A321;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rowwrite;
  logic [3:0]  colread;
  logic        ack = 1'b0;
  logic        statusordata = 1'b0;
  logic [15:0] keyout;

  // Keypad model: one key, shorts its column low while its row is driven.
  logic        kp_on = 1'b0;
  int          kp_row = 0;
  int          kp_col = 0;
  logic [3:0]  kp_mask;

  always_comb begin
    kp_mask = 4'hF;
    if (kp_on && !rowwrite[kp_row]) kp_mask[kp_col] = 1'b0;
  end
  assign colread = kp_mask;

  keypad_scan_fifo #(
    .ROWS(4), .COLS(4), .SCAN_DIV(2), .DEBOUNCE(3), .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rowwrite     (rowwrite),
    .colread      (colread),
    .ack          (ack),
    .statusordata (statusordata),
    .keyout       (keyout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: stimulus pushes expectations, monitor pops on each read.
  logic [15:0] q_exp  [$];
  int          q_kind [$];
  string       q_name [$];
  logic        rd_en = 1'b0;

  logic [15:0] m_exp;
  logic [15:0] m_act;
  int          m_kind;
  string       m_name;

  always @(negedge clk) begin
    if (rd_en) begin
      checks++;
      if (q_exp.size() == 0) begin
        errors++;
        $display("FAIL monitor: read with empty scoreboard");
      end else begin
        m_exp  = q_exp.pop_front();
        m_kind = q_kind.pop_front();
        m_name = q_name.pop_front();
        m_act  = (m_kind == 1) ? {12'h000, rowwrite} : keyout;
        if (m_act !== m_exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", m_name, m_act, m_exp);
        end
      end
    end
  end

  function automatic logic [15:0] kcode(input int r, input int c);
`ifdef KEYPAD_HEXMAP_EN
    return {12'h000, LEGEND[(r*4+c)*4 +: 4]};
`else
    return 16'(r*4 + c);
`endif
  endfunction

  task automatic rd(input logic sel, input logic [15:0] e, input string n);
    statusordata = sel;
    q_exp.push_back(e); q_kind.push_back(0); q_name.push_back(n);
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    statusordata = 1'b0;
  endtask

  task automatic rd_row(input logic [15:0] e, input string n);
    q_exp.push_back(e); q_kind.push_back(1); q_name.push_back(n);
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int r, input int c);
    kp_row = r; kp_col = c; kp_on = 1'b1;
    idle(70);
    kp_on = 1'b0;
    idle(70);
  endtask

  task automatic ack_edge(input logic sel);
    statusordata = sel;
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
    idle(1);
    statusordata = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    idle(3);
    rst = 1'b0;
    // Reset state and row rotation every 4 clocks.
    rd_row(16'h000E, "reset_row");
    rd(1'b1, 16'h0000, "reset_status");
    idle(2);
    rd_row(16'h000D, "row1");
    idle(3);
    rd_row(16'h000B, "row2");
    idle(3);
    rd_row(16'h0007, "row3");
    idle(3);
    rd_row(16'h000E, "row_wrap");
    idle(100);
    rd(1'b1, 16'h0000, "idle_status");
    rd(1'b0, 16'h0000, "idle_data_empty");

    // Two-scan glitch must not register.
    kp_row = 2; kp_col = 3; kp_on = 1'b1;
    idle(28);
    kp_on = 1'b0;
    idle(70);
    rd(1'b1, 16'h0000, "glitch_status");

    press(1, 1);
    rd(1'b1, 16'h0101, "press1_status");
    rd(1'b0, kcode(1, 1), "press1_data");
    press(0, 0);
    rd(1'b1, 16'h0201, "press2_status");
    press(2, 3);
    rd(1'b1, 16'h0301, "press3_status");
    press(3, 2);
    rd(1'b1, 16'h0401, "press4_status");
    press(0, 3);
    rd(1'b1, 16'h0403, "overflow_status");
    rd(1'b0, kcode(1, 1), "overflow_head");

    // Held ack pops once.
    statusordata = 1'b0;
    ack = 1'b1;
    idle(20);
    ack = 1'b0;
    idle(1);
    rd(1'b1, 16'h0303, "held_ack_status");
    rd(1'b0, kcode(0, 0), "held_ack_head");

    ack_edge(1'b1);
    rd(1'b1, 16'h0301, "ovf_clear_status");
    rd(1'b0, kcode(0, 0), "ovf_clear_head");

    press(2, 0);
    rd(1'b1, 16'h0401, "refill_status");

    // Align a press to row1 so the event cycle is known, then pop in it.
    n = 0;
    while (rowwrite == 4'b1101 && n < 50) begin idle(1); n++; end
    while (rowwrite != 4'b1101 && n < 100) begin idle(1); n++; end
    checks++;
    if (rowwrite != 4'b1101) begin
      errors++;
      $display("FAIL sync_row1: got %h expected d", rowwrite);
    end
    kp_row = 1; kp_col = 2; kp_on = 1'b1;
    repeat (36) @(posedge clk);
    #1;
    statusordata = 1'b0;
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
    idle(40);
    kp_on = 1'b0;
    idle(70);
    rd(1'b1, 16'h0401, "collide_status");
    rd(1'b0, kcode(2, 3), "collide_head");
    ack_edge(1'b0);
    rd(1'b0, kcode(3, 2), "pop_k4");
    ack_edge(1'b0);
    rd(1'b0, kcode(2, 0), "pop_k5");
    ack_edge(1'b0);
    rd(1'b0, kcode(1, 2), "pop_tail");
    rd(1'b1, 16'h0101, "pop_tail_status");
    ack_edge(1'b0);
    rd(1'b0, 16'h0000, "empty_data");
    rd(1'b1, 16'h0000, "empty_status");
    ack_edge(1'b0);
    rd(1'b1, 16'h0000, "pop_empty_status");

    // Reset mid-press discards state.
    press(3, 3);
    kp_on = 1'b1;
    idle(10);
    rst = 1'b1;
    idle(1);
    rd_row(16'h000E, "rst2_row");
    rd(1'b1, 16'h0000, "rst2_status");
    rst = 1'b0;
    kp_on = 1'b0;
    idle(5);

    n = 0;
    while (q_exp.size() != 0 && n < 10) begin idle(1); n++; end
    if (q_exp.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q_exp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
